minterm_sweep_capture: RTL

//  Self-test driver/capture stage wrapped around the 3-input decoder/function block.
//  On a start pulse it drives a,b,c through minterms 0..7, waits a settle time, and samples f1/f2/f3 into 8-bit truth tables.
//  It then compares the tables against expected constants and reports pass/fail plus the first failing minterm.

---
 rtl/minterm_sweep_capture.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/minterm_sweep_capture.sv
// ============================================================================
//  Module   : minterm_sweep_capture
//  Purpose  : Sweeps a 3-input decoder through minterms 0..7, captures f1/f2/f3
//             truth tables and compares them against expected constants.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module minterm_sweep_capture #(
    parameter int         SETTLE_CYCLES = 1,
    parameter logic [7:0] EXP_F1        = 8'h94,
    parameter logic [7:0] EXP_F2        = 8'h09,
    parameter logic [7:0] EXP_F3        = 8'h9D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       f1,
    input  logic       f2,
    input  logic       f3,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt_f1,
    output logic [7:0] tt_f2,
    output logic [7:0] tt_f3,
    output logic       match,
    output logic [2:0] err_idx
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] C_SETTLE_LOAD = 4'(SETTLE_CYCLES);

    logic [1:0] r_state;
    logic [2:0] r_idx;
    logic [3:0] r_cnt;
    logic       r_err;
    logic [2:0] r_abc;
    logic [7:0] r_tt_f1;
    logic [7:0] r_tt_f2;
    logic [7:0] r_tt_f3;
    logic       r_match;
    logic [2:0] r_err_idx;
    logic       r_done;
    logic       r_busy;

    logic       w_mismatch;
    logic       w_err_any;

    assign w_mismatch = ({f1, f2, f3} != {EXP_F1[r_idx], EXP_F2[r_idx], EXP_F3[r_idx]});
    // Includes the minterm being sampled now, so match is valid in the DONE cycle.
    assign w_err_any  = r_err | w_mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= 3'd0;
            r_cnt     <= 4'd0;
            r_err     <= 1'b0;
            r_abc     <= 3'd0;
            r_tt_f1   <= 8'h00;
            r_tt_f2   <= 8'h00;
            r_tt_f3   <= 8'h00;
            r_match   <= 1'b0;
            r_err_idx <= 3'd0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_tt_f1 <= 8'h00;
                        r_tt_f2 <= 8'h00;
                        r_tt_f3 <= 8'h00;
                        r_idx   <= 3'd0;
                        r_err   <= 1'b0;
                        r_cnt   <= C_SETTLE_LOAD;
                        r_abc   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt <= 4'd1) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    r_tt_f1[r_idx] <= f1;
                    r_tt_f2[r_idx] <= f2;
                    r_tt_f3[r_idx] <= f3;
                    if (w_mismatch && !r_err) begin
                        r_err     <= 1'b1;
                        r_err_idx <= r_idx;
                    end
                    if (r_idx == 3'd7) begin
                        r_done  <= 1'b1;
                        r_match <= ~w_err_any;
                        if (!w_err_any) begin
                            r_err_idx <= 3'd0;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                        r_abc   <= r_idx + 3'd1;
                        r_cnt   <= C_SETTLE_LOAD;
                        r_state <= S_SETTLE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_abc   <= 3'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign {a, b, c} = r_abc;
    assign busy      = r_busy;
    assign done      = r_done;
    assign tt_f1     = r_tt_f1;
    assign tt_f2     = r_tt_f2;
    assign tt_f3     = r_tt_f3;
    assign match     = r_match;
    assign err_idx   = r_err_idx;

endmodule

`default_nettype wire
